// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and arbiter types for the bus arbiter and the DMA scheduler.
package ahb_pkg;

  localparam int BEAT_W = 4;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'b000,
    HSIZE_HALF  = 3'b001,
    HSIZE_WORD  = 3'b010,
    HSIZE_DWORD = 3'b011
  } hsize_e;

  typedef enum logic [1:0] {
    ARB    = 2'b00,
    BURST  = 2'b01,
    HOLD   = 2'b10,
    LOCKED = 2'b11
  } arb_state_e;

  // Beats still to come after the NONSEQ; zero for SINGLE and undefined-length INCR.
  function automatic logic [BEAT_W-1:0] burst_beats(input logic [2:0] hburst);
    case (hburst_e'(hburst))
      HBURST_INCR4,  HBURST_WRAP4:  return BEAT_W'(3);
      HBURST_INCR8,  HBURST_WRAP8:  return BEAT_W'(7);
      HBURST_INCR16, HBURST_WRAP16: return BEAT_W'(15);
      default:                      return '0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin picker: first requester after the pointer, wrapping modulo N.
module ahb_rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_rr,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    // Walk from farthest to nearest so the requester closest after i_rr is assigned last.
    for (int k = N; k >= 1; k--) begin
      for (int m = 0; m < N; m++) begin
        if (m == (int'(i_rr) + k) % N && i_req[m]) o_idx = IDX_W'(m);
      end
    end
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// AHB-Lite bus arbiter: round-robin grant with default master, held across bursts,
// undefined INCR sequences and locked sequences; drives address/data-phase mux selects.
module ahb_bus_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int MIDX_W         = 2,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   HCLK,
  input  logic                   RESET,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  input  logic                   HRESP,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MIDX_W-1:0]      HMASTER,
  output logic [MIDX_W-1:0]      HMASTER_D,
  output logic                   HMASTLOCK
);

  localparam logic [MIDX_W-1:0]      DEF_IDX = MIDX_W'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_OH  = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

  arb_state_e               r_state;
  logic [NUM_MASTERS-1:0]   r_grant;
  logic [MIDX_W-1:0]        r_owner;
  logic [MIDX_W-1:0]        r_rr;
  logic [MIDX_W-1:0]        r_hmaster;
  logic [MIDX_W-1:0]        r_hmaster_d;
  logic                     r_mastlock;
  logic                     r_unlock;
  logic [BEAT_W-1:0]        r_beat_cnt;

  logic [MIDX_W-1:0]        w_pick;
  logic                     w_valid;
  logic [MIDX_W-1:0]        w_winner;
  logic [NUM_MASTERS-1:0]   w_winner_oh;
  logic                     w_win_lock;
  logic                     w_owner_req;
  logic                     w_owner_lock;
  logic                     w_handover;
  logic                     w_nonseq;
  logic                     w_fixed;
  logic                     w_incr_hold;
  logic                     w_do_rearb;
  logic                     w_error;

  ahb_rr_picker #(.N(NUM_MASTERS), .IDX_W(MIDX_W)) u_picker (
    .i_req   (HBUSREQ),
    .i_rr    (r_rr),
    .o_idx   (w_pick),
    .o_valid (w_valid)
  );

  always_comb begin
    w_winner     = w_valid ? w_pick : DEF_IDX;
    w_winner_oh  = '0;
    w_win_lock   = 1'b0;
    w_owner_req  = 1'b0;
    w_owner_lock = 1'b0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      w_winner_oh[m] = (w_winner == MIDX_W'(m));
      if (w_winner == MIDX_W'(m)) w_win_lock = HLOCK[m];
      if (r_owner == MIDX_W'(m)) begin
        w_owner_req  = HBUSREQ[m];
        w_owner_lock = HLOCK[m];
      end
    end
    w_error     = HRESP && !HREADY;
    // A granted master does not own the bus until HMASTER catches up; its first
    // transfer must be seen before the grant can move again.
    w_handover  = (r_hmaster != r_owner);
    w_nonseq    = (HTRANS == HTRANS_NONSEQ);
    w_fixed     = (burst_beats(HBURST) != '0);
    w_incr_hold = (HBURST == HBURST_INCR) && w_owner_req;
    w_do_rearb  = 1'b0;
    if (HREADY) begin
      case (r_state)
        ARB:     w_do_rearb = !w_handover && !(w_nonseq && (w_fixed || w_incr_hold));
        BURST:   w_do_rearb = (HTRANS == HTRANS_SEQ) && (r_beat_cnt == BEAT_W'(1));
        HOLD:    w_do_rearb = !w_owner_req;
        LOCKED:  w_do_rearb = !w_owner_lock && r_unlock;
        default: w_do_rearb = 1'b0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge HCLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= ARB;
      r_grant     <= DEF_OH;
      r_owner     <= DEF_IDX;
      r_rr        <= DEF_IDX;
      r_hmaster   <= DEF_IDX;
      r_hmaster_d <= DEF_IDX;
      r_mastlock  <= 1'b0;
      r_unlock    <= 1'b0;
      r_beat_cnt  <= '0;
    end else begin
      if (HREADY) begin
        r_hmaster   <= r_owner;
        r_hmaster_d <= r_hmaster;
        r_mastlock  <= (r_state == LOCKED);
      end

      if (w_error)                                                  r_beat_cnt <= '0;
      else if (HREADY && w_nonseq)                                  r_beat_cnt <= burst_beats(HBURST);
      else if (HREADY && HTRANS == HTRANS_SEQ && r_beat_cnt != '0)  r_beat_cnt <= r_beat_cnt - BEAT_W'(1);

      if (w_error) begin
        r_state  <= ARB;
        r_unlock <= 1'b0;
      end else if (w_do_rearb) begin
        r_grant  <= w_winner_oh;
        r_owner  <= w_winner;
        r_unlock <= 1'b0;
        if (w_valid) r_rr <= w_winner;
        r_state  <= (w_valid && w_win_lock) ? LOCKED : ARB;
      end else if (HREADY) begin
        case (r_state)
          ARB: begin
            if (!w_handover && w_nonseq) begin
              if (w_fixed)          r_state <= BURST;
              else if (w_incr_hold) r_state <= HOLD;
            end
          end
          // The release waits one more accepted cycle so the last locked data phase completes.
          LOCKED:  r_unlock <= !w_owner_lock;
          default: ;
        endcase
      end
    end
  end

  assign HGRANT    = r_grant;
  assign HMASTER   = r_hmaster;
  assign HMASTER_D = r_hmaster_d;
  assign HMASTLOCK = r_mastlock;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter: reset, round-robin, bursts, INCR hold, lock and error release.
module tb_ahb_bus_arbiter;
  import ahb_pkg::*;

  logic       HCLK = 1'b0;
  logic       RESET = 1'b0;
  logic [1:0] HBUSREQ = '0;
  logic [1:0] HLOCK = '0;
  logic [1:0] HTRANS = HTRANS_IDLE;
  logic [2:0] HBURST = HBURST_SINGLE;
  logic       HREADY = 1'b1;
  logic       HRESP = 1'b0;
  logic [1:0] HGRANT;
  logic [1:0] HMASTER;
  logic [1:0] HMASTER_D;
  logic       HMASTLOCK;

  int checks   = 0;
  int failures = 0;

  ahb_bus_arbiter #(.NUM_MASTERS(2), .MIDX_W(2), .DEFAULT_MASTER(0)) dut (
    .HCLK      (HCLK),
    .RESET     (RESET),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HTRANS    (HTRANS),
    .HBURST    (HBURST),
    .HREADY    (HREADY),
    .HRESP     (HRESP),
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTER_D (HMASTER_D),
    .HMASTLOCK (HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    HBUSREQ = '0; HLOCK = '0; HTRANS = HTRANS_IDLE; HBURST = HBURST_SINGLE;
    HREADY = 1'b1; HRESP = 1'b0;
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
  endtask

  initial begin
    // Reset values
    do_reset();
    chk("rst_grant", 32'(HGRANT), 32'h1);
    chk("rst_hmaster", 32'(HMASTER), 32'h0);
    chk("rst_hmaster_d", 32'(HMASTER_D), 32'h0);
    chk("rst_mastlock", 32'(HMASTLOCK), 32'h0);

    // Two masters issuing SINGLEs: M1 first, then alternate; HMASTER_D trails HMASTER
    HBUSREQ = 2'b11; HTRANS = HTRANS_NONSEQ; HBURST = HBURST_SINGLE;
    tick(); chk("rr_e1_grant", 32'(HGRANT), 32'h2); chk("rr_e1_hm", 32'(HMASTER), 32'h0);
    tick(); chk("rr_e2_grant", 32'(HGRANT), 32'h2); chk("rr_e2_hm", 32'(HMASTER), 32'h1);
            chk("rr_e2_hmd", 32'(HMASTER_D), 32'h0);
    tick(); chk("rr_e3_grant", 32'(HGRANT), 32'h1); chk("rr_e3_hm", 32'(HMASTER), 32'h1);
            chk("rr_e3_hmd", 32'(HMASTER_D), 32'h1);
    tick(); chk("rr_e4_hm", 32'(HMASTER), 32'h0); chk("rr_e4_hmd", 32'(HMASTER_D), 32'h1);
    tick(); chk("rr_e5_grant", 32'(HGRANT), 32'h2); chk("rr_e5_hmd", 32'(HMASTER_D), 32'h0);

    // M1 INCR4 with a two-cycle stall on beat 3, M0 requesting throughout
    do_reset();
    HBUSREQ = 2'b11;
    tick(); chk("b4_grant_m1", 32'(HGRANT), 32'h2);
    tick(); chk("b4_owner_m1", 32'(HMASTER), 32'h1);
    HTRANS = HTRANS_NONSEQ; HBURST = HBURST_INCR4;
    tick(); chk("b4_beat1", 32'(HGRANT), 32'h2);
    HTRANS = HTRANS_SEQ;
    tick(); chk("b4_beat2", 32'(HGRANT), 32'h2);
    HREADY = 1'b0;
    tick(); chk("b4_wait1", 32'(HGRANT), 32'h2);
    tick(); chk("b4_wait2", 32'(HGRANT), 32'h2); chk("b4_wait_hm", 32'(HMASTER), 32'h1);
    HREADY = 1'b1;
    tick(); chk("b4_beat3", 32'(HGRANT), 32'h2);
    tick(); chk("b4_beat4_handover", 32'(HGRANT), 32'h1);
    HTRANS = HTRANS_IDLE; HBUSREQ = 2'b01;
    tick(); chk("b4_m0_owner", 32'(HMASTER), 32'h0); chk("b4_m0_grant", 32'(HGRANT), 32'h1);

    // Reset asserted in the middle of an INCR4 returns outputs asynchronously
    do_reset();
    HBUSREQ = 2'b11;
    tick(); tick();
    HTRANS = HTRANS_NONSEQ; HBURST = HBURST_INCR4;
    tick();
    HTRANS = HTRANS_SEQ;
    tick();
    chk("mid_pre_grant", 32'(HGRANT), 32'h2);
    #2 RESET = 1'b0;
    #1;
    chk("mid_rst_grant", 32'(HGRANT), 32'h1);
    chk("mid_rst_hm", 32'(HMASTER), 32'h0);
    chk("mid_rst_hmd", 32'(HMASTER_D), 32'h0);
    chk("mid_rst_lock", 32'(HMASTLOCK), 32'h0);

    // M0 undefined INCR of 6 beats, M1 joins and takes over when M0 drops its request
    do_reset();
    HBUSREQ = 2'b01; HTRANS = HTRANS_NONSEQ; HBURST = HBURST_INCR;
    tick(); chk("incr_beat1", 32'(HGRANT), 32'h1);
    HBUSREQ = 2'b11; HTRANS = HTRANS_SEQ;
    for (int b = 2; b <= 5; b++) begin
      tick(); chk($sformatf("incr_beat%0d", b), 32'(HGRANT), 32'h1);
    end
    HBUSREQ = 2'b10;
    tick(); chk("incr_release", 32'(HGRANT), 32'h2);
    HTRANS = HTRANS_IDLE;
    tick(); chk("incr_m1_owner", 32'(HMASTER), 32'h1);

    // M1 locked sequence of two SINGLEs with M0 waiting
    do_reset();
    HBUSREQ = 2'b11; HLOCK = 2'b10;
    tick(); chk("lk_grant", 32'(HGRANT), 32'h2); chk("lk_pre", 32'(HMASTLOCK), 32'h0);
    HTRANS = HTRANS_NONSEQ;
    tick(); chk("lk_ap1_hm", 32'(HMASTER), 32'h1); chk("lk_ap1", 32'(HMASTLOCK), 32'h1);
    tick(); chk("lk_ap2", 32'(HMASTLOCK), 32'h1); chk("lk_ap2_grant", 32'(HGRANT), 32'h2);
    HLOCK = 2'b00; HBUSREQ = 2'b01;
    tick(); chk("lk_extra_cycle", 32'(HGRANT), 32'h2);
    HTRANS = HTRANS_IDLE;
    tick(); chk("lk_release", 32'(HGRANT), 32'h1);
    tick(); chk("lk_m0_owner", 32'(HMASTER), 32'h0); chk("lk_off", 32'(HMASTLOCK), 32'h0);

    // ERROR on beat 2 of an M0 INCR8 releases the bus
    do_reset();
    HBUSREQ = 2'b01; HTRANS = HTRANS_NONSEQ; HBURST = HBURST_INCR8;
    tick(); chk("err_beat1", 32'(HGRANT), 32'h1);
    HBUSREQ = 2'b11; HTRANS = HTRANS_SEQ;
    tick(); chk("err_beat2", 32'(HGRANT), 32'h1);
    HREADY = 1'b0; HRESP = 1'b1;
    tick();
    chk("err_state", 32'(dut.r_state), 32'(ARB));
    chk("err_cnt", 32'(dut.r_beat_cnt), 32'h0);
    chk("err_grant_hold", 32'(HGRANT), 32'h1);
    HREADY = 1'b1; HTRANS = HTRANS_IDLE;
    tick(); chk("err_m1_grant", 32'(HGRANT), 32'h2);
    HRESP = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
